// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating
// direction counters, plus committed-branch and misprediction counters.
//
// Update handshake: br_valid marks a resolved beq/bne presented on
// br_pc/br_result/br_pred/braddr. upd_en is the pipeline-advance qualifier.
// An update commits only on a rising CLK edge where br_valid && upd_en is
// high. There is no back-pressure: the predictor always accepts a commit.
// A branch held across stall cycles (br_valid=1, upd_en=0) is applied once,
// on the cycle upd_en rises.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic        taken,
  output logic [31:0] target,
  input  logic        br_valid,
  input  logic        upd_en,
  input  logic [31:0] br_pc,
  input  logic        br_result,
  input  logic        br_pred,
  input  logic [31:0] braddr,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_MAX     = 2'b11;
  localparam logic [1:0] CTR_MIN     = 2'b00;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  // Reset value of every entry: invalid, weakly not-taken.
  localparam entry_t RESET_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: 32'h0,
    ctr:    CTR_WEAK_NT
  };

  // One step up, sticking at strong taken.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
  endfunction

  // One step down, sticking at strong not-taken.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
  endfunction

  // Table storage: flops, so lookups see the state as of the last edge.
  entry_t btb_q [ENTRIES];

  // Lookup side signals.
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  entry_t           rd_entry;
  logic             rd_hit;

  // Update side signals.
  logic             commit;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  entry_t           wr_entry;
  logic             wr_hit;
  logic             wr_en;
  entry_t           wr_next;

  // Performance counters.
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;
  logic        mispredict;

  // The byte-offset bits of both PCs carry no information for word-aligned
  // instructions; they are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[1:0], br_pc[1:0]};

  assign rd_idx = pc[IDX_W+1:2];
  assign rd_tag = pc[31:IDX_W+2];
  assign wr_idx = br_pc[IDX_W+1:2];
  assign wr_tag = br_pc[31:IDX_W+2];
  assign commit = br_valid && upd_en;

  // Combinational prediction for the fetch PC from the registered table.
  always_comb begin
    rd_entry = btb_q[rd_idx];
    rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);
    taken    = rd_hit && rd_entry.ctr[1];
    target   = taken ? rd_entry.target : 32'h0;
  end

  // Next value of the entry addressed by br_pc, and whether it is written.
  always_comb begin
    wr_entry = btb_q[wr_idx];
    wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);
    wr_next  = wr_entry;
    wr_en    = 1'b0;
    if (commit) begin
      if (wr_hit) begin
        wr_en = 1'b1;
        if (br_result) begin
          wr_next.ctr    = ctr_inc(wr_entry.ctr);
          wr_next.target = braddr;
        end else begin
          wr_next.ctr    = ctr_dec(wr_entry.ctr);
        end
      end else if (br_result) begin
        // Taken branch with no matching entry: allocate, or evict the alias.
        wr_en          = 1'b1;
        wr_next.valid  = 1'b1;
        wr_next.tag    = wr_tag;
        wr_next.target = braddr;
        wr_next.ctr    = CTR_WEAK_T;
      end
      // Not-taken miss: nothing worth remembering, table left alone.
    end
  end

  // Table register: asynchronous clear, single write port at the commit index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= RESET_ENTRY;
      end
    end else if (wr_en) begin
      btb_q[wr_idx] <= wr_next;
    end
  end

  assign mispredict = (br_pred != br_result);

  // Committed-branch counter, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_count_q <= 32'h0;
    end else if (commit && (br_count_q != 32'hFFFF_FFFF)) begin
      br_count_q <= br_count_q + 32'd1;
    end
  end

  // Misprediction counter, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispred_count_q <= 32'h0;
    end else if (commit && mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
      mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test of the BTB lookup, training, aliasing,
// same-cycle ordering, stall qualification, counters and asynchronous reset.
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc;
  logic        taken;
  logic [31:0] target;
  logic        br_valid;
  logic        upd_en;
  logic [31:0] br_pc;
  logic        br_result;
  logic        br_pred;
  logic [31:0] braddr;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  branch_predictor #(.IDX_W(4)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .pc            (pc),
    .taken         (taken),
    .target        (target),
    .br_valid      (br_valid),
    .upd_en        (upd_en),
    .br_pc         (br_pc),
    .br_result     (br_result),
    .br_pred       (br_pred),
    .braddr        (braddr),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present one committing update for a single cycle; returns at posedge+1.
  task automatic commit(input logic [31:0] a, input logic r, input logic p, input logic [31:0] t);
    @(negedge CLK);
    br_valid  = 1'b1;
    upd_en    = 1'b1;
    br_pc     = a;
    br_result = r;
    br_pred   = p;
    braddr    = t;
    @(posedge CLK);
    #1;
    br_valid  = 1'b0;
    upd_en    = 1'b0;
  endtask

  task automatic look(input logic [31:0] a);
    pc = a;
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    nRST = 1'b0; pc = 32'h40; br_valid = 1'b0; upd_en = 1'b0;
    br_pc = 32'h0; br_result = 1'b0; br_pred = 1'b0; braddr = 32'h0;

    // Reset lookup
    #1;
    check("rst_taken", {31'h0, taken}, 32'h0);
    check("rst_target", target, 32'h0);
    check("rst_br_count", br_count, 32'h0);
    check("rst_mispred", mispred_count, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Allocate 0x40 -> 0x100, ctr=10
    commit(32'h40, 1'b1, 1'b0, 32'h100);
    look(32'h40);
    check("alloc_taken", {31'h0, taken}, 32'h1);
    check("alloc_target", target, 32'h100);
    check("alloc_br_count", br_count, 32'h1);
    check("alloc_mispred", mispred_count, 32'h1);

    // Counter walk down: 10 -> 01 -> 00
    commit(32'h40, 1'b0, 1'b1, 32'h0);
    look(32'h40);
    check("walk_nt1_taken", {31'h0, taken}, 32'h0);
    check("walk_nt1_target", target, 32'h0);
    commit(32'h40, 1'b0, 1'b0, 32'h0);
    look(32'h40);
    check("walk_nt2_taken", {31'h0, taken}, 32'h0);
    // Walk up: 00 -> 01 (still NT proves the previous step reached 00)
    commit(32'h40, 1'b1, 1'b0, 32'h100);
    look(32'h40);
    check("walk_t1_taken", {31'h0, taken}, 32'h0);
    commit(32'h40, 1'b1, 1'b0, 32'h100);
    look(32'h40);
    check("walk_t2_taken", {31'h0, taken}, 32'h1);
    commit(32'h40, 1'b1, 1'b1, 32'h100);
    look(32'h40);
    check("walk_t3_taken", {31'h0, taken}, 32'h1);
    // Fourth taken commit saturates at 11 and refreshes the target
    commit(32'h40, 1'b1, 1'b1, 32'h104);
    look(32'h40);
    check("walk_t4_taken", {31'h0, taken}, 32'h1);
    check("walk_t4_target", target, 32'h104);
    // 11 -> 10 keeps taken and target; 10 -> 01 drops it
    commit(32'h40, 1'b0, 1'b1, 32'h999);
    look(32'h40);
    check("walk_sat_taken", {31'h0, taken}, 32'h1);
    check("walk_sat_target", target, 32'h104);
    commit(32'h40, 1'b0, 1'b1, 32'h999);
    look(32'h40);
    check("walk_down_taken", {31'h0, taken}, 32'h0);
    check("walk_br_count", br_count, 32'd9);
    check("walk_mispred", mispred_count, 32'd6);
    // Back to 10 for the aliasing test
    commit(32'h40, 1'b1, 1'b0, 32'h100);
    look(32'h40);
    check("walk_back_taken", {31'h0, taken}, 32'h1);

    // Aliasing on index 0
    look(32'h80);
    check("alias_miss_taken", {31'h0, taken}, 32'h0);
    commit(32'h80, 1'b1, 1'b0, 32'h200);
    look(32'h40);
    check("alias_evicted_taken", {31'h0, taken}, 32'h0);
    look(32'h80);
    check("alias_new_taken", {31'h0, taken}, 32'h1);
    check("alias_new_target", target, 32'h200);
    // Not-taken commit for the evicted (missing) PC leaves the table alone
    commit(32'h40, 1'b0, 1'b0, 32'h999);
    look(32'h80);
    check("miss_nt_taken", {31'h0, taken}, 32'h1);
    check("miss_nt_target", target, 32'h200);
    look(32'h40);
    check("miss_nt_other", {31'h0, taken}, 32'h0);
    check("miss_nt_br_count", br_count, 32'd12);
    check("miss_nt_mispred", mispred_count, 32'd8);

    // Same-cycle lookup and commit on 0x80 (ctr=10): pre-update state seen
    @(negedge CLK);
    pc = 32'h80; br_valid = 1'b1; upd_en = 1'b1;
    br_pc = 32'h80; br_result = 1'b0; br_pred = 1'b1; braddr = 32'h0;
    #1;
    check("same_cycle_taken", {31'h0, taken}, 32'h1);
    @(posedge CLK);
    #1;
    br_valid = 1'b0; upd_en = 1'b0;
    check("same_cycle_next", {31'h0, taken}, 32'h0);

    // Stall: br_valid held 3 cycles, upd_en = 0,0,1 -> counted once
    exp_q.push_back(32'd13);
    exp_q.push_back(32'd13);
    exp_q.push_back(32'd14);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      br_valid = 1'b1; upd_en = (i == 2); br_pc = 32'h80;
      br_result = 1'b1; br_pred = 1'b0; braddr = 32'h200;
      @(posedge CLK);
      #1;
      check($sformatf("stall_br_count_%0d", i), br_count, exp_q.pop_front());
      check($sformatf("stall_taken_%0d", i), {31'h0, taken}, (i == 2) ? 32'h1 : 32'h0);
    end
    br_valid = 1'b0; upd_en = 1'b0;
    check("stall_mispred", mispred_count, 32'd10);

    // Fresh reset wipes the table and counters
    reset_pulse();
    look(32'h80);
    check("pulse_taken", {31'h0, taken}, 32'h0);
    check("pulse_br_count", br_count, 32'h0);

    // Five commits on 0x48, two mispredicted
    commit(32'h48, 1'b1, 1'b0, 32'h300);
    commit(32'h48, 1'b1, 1'b1, 32'h300);
    commit(32'h48, 1'b1, 1'b1, 32'h300);
    commit(32'h48, 1'b0, 1'b1, 32'h300);
    commit(32'h48, 1'b1, 1'b1, 32'h300);
    look(32'h48);
    check("five_br_count", br_count, 32'd5);
    check("five_mispred", mispred_count, 32'd2);
    check("five_taken", {31'h0, taken}, 32'h1);
    check("five_target", target, 32'h300);

    // Mid-cycle asynchronous reset, no clock edge needed
    #1;
    nRST = 1'b0;
    #1;
    check("async_taken", {31'h0, taken}, 32'h0);
    check("async_target", target, 32'h0);
    check("async_br_count", br_count, 32'h0);
    check("async_mispred", mispred_count, 32'h0);
    // Update presented while reset is held is discarded
    br_valid = 1'b1; upd_en = 1'b1; br_pc = 32'h48;
    br_result = 1'b1; br_pred = 1'b0; braddr = 32'h300;
    @(posedge CLK);
    #1;
    br_valid = 1'b0; upd_en = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("rst_upd_br_count", br_count, 32'h0);
    check("rst_upd_mispred", mispred_count, 32'h0);
    check("rst_upd_taken", {31'h0, taken}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
